// File: rtl/stream_pkg.sv
// Shared definitions for the stream arbitration blocks: arbiter FSM states
// and the wrap-around round-robin search.
package stream_pkg;

  localparam int MAX_PORTS = 64;
  localparam int PTR_W     = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // First set bit of req at or above ptr, wrapping at num; returns ptr when req is empty.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                               input logic [PTR_W-1:0]     ptr,
                                               input int                   num);
    logic [PTR_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      if (k < num) begin
        idx = int'(ptr) + k;
        if (idx >= num) idx = idx - num;
        if (!found && req[idx]) begin
          pick  = PTR_W'(idx);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/stream_skid.sv
// Two-entry registered skid buffer: output straight from flops, input ready
// registered, so there is no combinational path from out_ready to in_ready.
module stream_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pay,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pay
);

  logic              skid_vld_p0;
  logic [DATA_W-1:0] skid_pay_p0;
  logic              out_vld_p1;
  logic [DATA_W-1:0] out_pay_p1;
  logic              push;
  logic              load_out;

  // The skid slot only fills while the output slot is occupied, so it alone
  // decides whether fewer than two entries are held.
  assign in_ready = !skid_vld_p0;
  assign push     = in_valid && in_ready;
  assign load_out = !out_vld_p1 || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_vld_p0 <= 1'b0;
      out_vld_p1  <= 1'b0;
    end else if (load_out) begin
      if (skid_vld_p0) begin
        out_vld_p1  <= 1'b1;
        skid_vld_p0 <= 1'b0;
      end else begin
        out_vld_p1  <= push;
      end
    end else if (push) begin
      skid_vld_p0 <= 1'b1;
    end
  end

  // p0: overflow slot, written only while the output slot is stalled
  always_ff @(posedge clk) begin
    if (!load_out && push) skid_pay_p0 <= in_pay;
  end

  // p1: output register; cleared on reset so the idle bus reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pay_p1 <= '0;
    end else if (load_out) begin
      if (skid_vld_p0)  out_pay_p1 <= skid_pay_p0;
      else if (push)    out_pay_p1 <= in_pay;
    end
  end

  assign out_valid = out_vld_p1;
  assign out_pay   = out_pay_p1;

endmodule

// File: rtl/stream_arb_mux.sv
// Packet-level round-robin merge of NUM_PORTS valid/ready streams; locks onto
// one port from first beat to last and registers the output via a skid buffer.
module stream_arb_mux
  import stream_pkg::*;
#(
  parameter int NUM_PORTS  = 6,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_PORTS-1:0]            s_valid,
  input  logic [NUM_PORTS-1:0]            s_last,
  output logic [NUM_PORTS-1:0]            s_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic [SEL_WIDTH-1:0]            m_sel,
  output logic                            m_last,
  output logic                            m_valid,
  input  logic                            m_ready
);

  localparam int                   PAY_W     = SEL_WIDTH + 1 + DATA_WIDTH;
  localparam logic [SEL_WIDTH-1:0] LAST_PORT = SEL_WIDTH'(NUM_PORTS - 1);

  arb_state_e            state_p0;
  logic [SEL_WIDTH-1:0]  sel_p0;
  logic [SEL_WIDTH-1:0]  ptr_p0;
  logic [SEL_WIDTH-1:0]  pick;
  logic                  skid_in_ready;
  logic                  in_vld;
  logic                  in_last;
  logic                  in_acc;
  logic [DATA_WIDTH-1:0] in_data;
  logic [PAY_W-1:0]      in_pay;
  logic [PAY_W-1:0]      out_pay;

  assign pick = SEL_WIDTH'(rr_pick(MAX_PORTS'(s_valid), PTR_W'(ptr_p0), NUM_PORTS));

  // p0: input mux for the locked port
  assign in_data = s_data[sel_p0*DATA_WIDTH +: DATA_WIDTH];
  assign in_last = s_last[sel_p0];
  assign in_vld  = (state_p0 == XFER) && s_valid[sel_p0];
  assign in_acc  = in_vld && skid_in_ready;
  assign in_pay  = {sel_p0, in_last, in_data};

  always_comb begin
    s_ready = '0;
    if (state_p0 == XFER) s_ready[sel_p0] = skid_in_ready;
  end

  // The lock is held through source gaps; only an accepted last beat releases it,
  // and the pointer moves past the served port so it loses the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      ptr_p0   <= '0;
      sel_p0   <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (|s_valid) begin
            sel_p0   <= pick;
            state_p0 <= XFER;
          end
        end
        XFER: begin
          if (in_acc && in_last) begin
            ptr_p0   <= (sel_p0 == LAST_PORT) ? '0 : sel_p0 + 1'b1;
            state_p0 <= IDLE;
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

  // p1: registered output through the skid buffer
  stream_skid #(
    .DATA_W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_vld),
    .in_ready  (skid_in_ready),
    .in_pay    (in_pay),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_pay   (out_pay)
  );

  assign {m_sel, m_last, m_data} = out_pay;

endmodule

// File: doc/stream_arb_mux.md
# stream_arb_mux

Packet-level round-robin multiplexer that merges `NUM_PORTS` valid/ready input streams onto one output stream. It locks onto one port from first beat to `last` beat, so packets are never interleaved. It sits directly downstream of the requesting units, in the position of the shared-bus arbiter stage, and feeds the single shared consumer. The output is registered through a 2-entry skid buffer, giving full throughput with no combinational path from `m_ready` to `s_ready`.

## Interface
- `NUM_PORTS`, 6: number of input streams; must be ≥ 1.
- `DATA_WIDTH`, 32: payload width per beat.
- `SEL_WIDTH`, `NUM_PORTS>1 ? $clog2(NUM_PORTS) : 1`: width of the port index.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `s_data`, in, `NUM_PORTS*DATA_WIDTH`: port `i` payload is bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_valid`, in, `NUM_PORTS`: per-port beat valid.
- `s_last`, in, `NUM_PORTS`: per-port end-of-packet flag.
- `s_ready`, out, `NUM_PORTS`: per-port ready; at most one bit is set.
- `m_data`, out, `DATA_WIDTH`: merged payload.
- `m_sel`, out, `SEL_WIDTH`: source port index of the current output beat.
- `m_last`, out, 1: end-of-packet flag of the current output beat.
- `m_valid`, out, 1: output beat valid.
- `m_ready`, in, 1: downstream ready.

## Operation
- A beat transfers on any side when valid and ready are both high at the clock edge.
- Two-state FSM:
  - IDLE: all `s_ready` = 0. If `|s_valid`, pick `p` = the first set bit of `s_valid` searching upward from `ptr` with wrap (`ptr`, `ptr+1`, …, `NUM_PORTS-1`, 0, …). Register `sel <= p` and go to XFER. If no `s_valid` bit is set, stay in IDLE.
  - XFER: `s_ready[sel]` = the skid buffer's input-ready; all other `s_ready` bits = 0. Each accepted beat `{s_data[sel], s_last[sel], sel}` enters the skid buffer. On an accepted beat with `s_last[sel]` = 1: `ptr <= (sel == NUM_PORTS-1) ? 0 : sel+1`, go to IDLE.
- While in XFER, deassertion of `s_valid[sel]` does not release the lock. A valid on any other port has no effect until the locked packet ends.
- `ptr` reset value is 0. This gives round-robin fairness: the port just served has the lowest priority at the next pick.
- Skid buffer behaviour:
  - Input-ready is high when it holds fewer than 2 entries.
  - Output is a register; `m_data`/`m_last`/`m_sel`/`m_valid` come straight from flops.
  - Order is preserved.
  - Never drops or duplicates a beat under any `m_ready` pattern.
- `NUM_PORTS` = 1: `sel` is always 0 and the FSM still passes through IDLE between packets.

## Timing
- Reset values, one cycle after `rst` high: state IDLE, `ptr` 0, `sel` 0, skid empty, `m_valid` 0, `m_data` 0, `m_last` 0, `m_sel` 0, `s_ready` all 0.
- Reset asserted mid-packet: the partial packet is discarded, including skid contents; no output beat is issued after the reset edge.
- Latency, with `s_valid[p]` first seen high in cycle T while IDLE:
  - cycle T: pick;
  - cycle T+1: `s_ready[p]` high, first beat accepted;
  - cycle T+2: `m_valid` high with that beat.
- Throughput inside a packet: 1 beat/cycle while `m_ready` = 1.
- Inter-packet bubble: exactly 1 cycle of all-zero `s_ready` (the IDLE cycle) after every `last` beat.
- `m_ready` low for any duration: `s_ready[sel]` drops the cycle after the skid fills (2 beats held). When `m_ready` returns, throughput resumes without a gap.
- `m_valid` high with `m_ready` low: `m_data`, `m_last` and `m_sel` hold stable until the transfer.

## Structure
- Shared package `stream_pkg`: function `rr_pick(req, ptr)` returning the first set index at or after `ptr` with wrap, and the FSM state enum `{IDLE, XFER}`.
- One sub-module: `stream_skid`, a 2-entry registered skid buffer parameterised by payload width. It carries `{sel, last, data}` as one payload.
- The top module holds the FSM, `ptr`, `sel`, the input mux and the `s_ready` decode.

## Test plan
- **Single packet.** Reset, then port 2 sends 3 beats (0xA0, 0xA1, 0xA2 with last), `m_ready` = 1. Expect: `m_valid` 2 cycles after the first `s_valid`; output 0xA0, 0xA1, 0xA2 on consecutive cycles, `m_sel` = 2, `m_last` only on 0xA2.
- **Round-robin order.** Ports 0, 3 and 5 each hold one 2-beat packet, all valid from reset release. Expect output packet order 0, 3, 5. Each packet is contiguous, with one idle cycle between packets.
- **Fairness and wrap.** Port 5 is served; ports 0 and 5 are then both valid. Expect port 0 next (`ptr` wraps to 0), then port 5.
- **No interleave.** Port 1 is mid-packet with `s_valid[1]` low for 3 cycles while port 4 is valid. Expect `s_ready[4]` = 0 throughout and port 1's remaining beats output before any port-4 beat.
- **Backpressure.** A 6-beat packet with `m_ready` toggling 1,0,0,1,0,1,… Expect all 6 beats in order with no drop or duplicate, and `m_data` stable while `m_valid` = 1 and `m_ready` = 0.
- **Reset mid-packet.** `rst` pulsed after 2 of 4 beats are accepted. Expect `m_valid` = 0 the next cycle and `s_ready` = 0; a new packet then arbitrates from `ptr` = 0.
